window_3x3: RTL and testbench
=============================

# window_3x3

Raster-to-neighbourhood stage between the bitmap pixel stream and the pixel-processing core. It accepts one pixel per enabled clock in row-major order, bottom row of the bitmap first, exactly as the stream arrives. It keeps the two previous image rows in internal line buffers. For every accepted pixel whose 3x3 neighbourhood lies fully inside the image, it emits that neighbourhood with the centre coordinates, ready for convolution kernels (Sobel, blur, threshold-morphology) downstream.

## Interface
- `DATA_W`, 8: bits per pixel sample.
- `MAX_WIDTH`, 1024: line buffer depth, and the maximum supported image width.
- `MAX_HEIGHT`, 1024: maximum supported image height.
- `clk`  in  1  single clock domain; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  pixel strobe; `data` is accepted on a rising edge while `en`=1.
- `data`  in  DATA_W  pixel sample.
- `width`  in  clog2(MAX_WIDTH+1)  image width in pixels, 3..MAX_WIDTH; held stable for the whole frame.
- `height`  in  clog2(MAX_HEIGHT+1)  image height in rows, 3..MAX_HEIGHT; held stable for the whole frame.
- `out`  out  9*DATA_W  window; tap k=3*r+c is at `out[k*DATA_W +: DATA_W]`.
  - r=0 is the oldest row, y-2; r=2 is the current row, y.
  - c=0 is column x-2; c=2 is column x.
- `out_valid`  out  1  `out`, `col` and `row` are valid this cycle.
- `col`  out  clog2(MAX_WIDTH)  centre column, x-1.
- `row`  out  clog2(MAX_HEIGHT)  centre row, y-1.
- `eof`  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Internal state:
  - input column counter x in 0..width-1.
  - input row counter y in 0..height-1.
  - line buffers `lb0` (row y-1) and `lb1` (row y-2), each MAX_WIDTH x DATA_W.
  - 3x3 register array.
- On an accepted pixel P at (x,y):
  - Read `lb1[x]` and `lb0[x]`, then write `lb1[x]`<=`lb0[x]` and `lb0[x]`<=P. Reads return the pre-write contents (read-before-write).
  - Shift the window one column left. The new c=2 column is {r0=old `lb1[x]`, r1=old `lb0[x]`, r2=P}.
  - Register `out_valid` <= (x>=2 && y>=2), `col` <= x-1, `row` <= y-1.
  - Advance x. At x=width-1, x wraps to 0 and y increments.
  - At (width-1,height-1), both counters wrap to 0 and `eof` <= 1.
- Cycle with `en`=0: counters, line buffers and window hold; `out_valid` <= 0; `eof` <= 0.
- Border pixels (x<2 or y<2) produce no valid output. The window may then hold stale or previous-row data; downstream must ignore it.
- Line buffer contents are not reset. Because of the y>=2 gate, their contents are never visible while `out_valid`=1.
- Frames run back-to-back with no gap. Line buffers are not cleared between frames; the y>=2 gate hides the previous frame's rows.
- Changing `width` or `height` mid-frame is illegal; behaviour is unspecified until the next reset.

## Timing
- Reset (`reset`=0, asynchronous):
  - x=0, y=0.
  - `out`=0, `out_valid`=0, `col`=0, `row`=0, `eof`=0.
  - Release is synchronous to `clk`; the first accepted pixel is on the first rising edge after release with `en`=1.
- Latency: `out`/`out_valid`/`col`/`row` update on the same edge that accepts the pixel, and are visible for one cycle after it.
- `out_valid` is high for exactly one cycle per qualifying accepted pixel.
- Throughput: one pixel per clock, with no stall input.
- Per frame: (width-2)*(height-2) valid outputs, then exactly one `eof` pulse.
- The `eof` pulse coincides with the last valid window (x=width-1, y=height-1).
- Reset asserted mid-frame: everything above clears immediately. The next accepted pixel is treated as (0,0).

## Test plan
- Valid-window timing and tap ordering:
  - Stimulus: reset, `width`=4, `height`=4, 16 consecutive pixels with value 4y+x.
  - Response: `out_valid` is high exactly after pixels 10, 11, 14 and 15.
  - First window taps k0..k8 = 0,1,2,4,5,6,8,9,10, with `col`=1, `row`=1.
  - Last window = 5,6,7,9,10,11,13,14,15, with `col`=2, `row`=2, and `eof`=1 in the same cycle.
- Enable gaps:
  - Stimulus: same stream as above, with `en` deasserted for 1–3 cycles at random.
  - Response: identical window sequence; `out_valid`=0 on every gap cycle; no tap changes during gaps.
- Back-to-back frames:
  - Stimulus: two 5x4 frames, second frame values = first + 100.
  - Response: 6 valid windows per frame; first valid window of frame 2 contains only values >=100; two `eof` pulses, 20 accepted pixels apart.
- Row wrap:
  - Stimulus: `width`=MAX_WIDTH, `height`=3, a ramp stream.
  - Response: MAX_WIDTH-2 valid windows; the last has `col`=MAX_WIDTH-2; no window straddles a row boundary.
- Reset mid-frame:
  - Stimulus: assert `reset` after pixel 7 of a 4x4 frame, then restart with a fresh 4x4 frame.
  - Response: all outputs 0 during reset; after release, the first valid window appears after the 11th new pixel, with correct taps.

Source files
------------

// File: rtl/window_3x3.sv
// Raster-to-3x3 neighbourhood stage: two line buffers plus a 3x3 register window,
// emitting a window for every accepted pixel whose neighbourhood lies inside the image.
module window_3x3 #(
   parameter int DATA_W     = 8,
   parameter int MAX_WIDTH  = 1024,
   parameter int MAX_HEIGHT = 1024
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              en,
   input  logic [DATA_W-1:0]                 data,
   input  logic [$clog2(MAX_WIDTH+1)-1:0]    width,
   input  logic [$clog2(MAX_HEIGHT+1)-1:0]   height,
   output logic [9*DATA_W-1:0]               out,
   output logic                              out_valid,
   output logic [$clog2(MAX_WIDTH)-1:0]      col,
   output logic [$clog2(MAX_HEIGHT)-1:0]     row,
   output logic                              eof
);

   localparam int WW = $clog2(MAX_WIDTH + 1);
   localparam int HW = $clog2(MAX_HEIGHT + 1);
   localparam int CW = $clog2(MAX_WIDTH);
   localparam int RW = $clog2(MAX_HEIGHT);

   logic [CW-1:0]          x_q, x_d;
   logic [RW-1:0]          y_q, y_d;
   logic [9*DATA_W-1:0]    win_q, win_d;
   logic                   valid_q, valid_d;
   logic [CW-1:0]          col_q, col_d;
   logic [RW-1:0]          row_q, row_d;
   logic                   eof_q, eof_d;

   logic [DATA_W-1:0]      lb0_q [MAX_WIDTH];
   logic [DATA_W-1:0]      lb1_q [MAX_WIDTH];
   logic [DATA_W-1:0]      lb0_rd_s;
   logic [DATA_W-1:0]      lb1_rd_s;
   logic [DATA_W-1:0]      new_col_s [3];
   logic                   last_col_s;
   logic                   last_row_s;

   assign lb0_rd_s   = lb0_q[x_q];
   assign lb1_rd_s   = lb1_q[x_q];
   assign last_col_s = (WW'(x_q) == (width - WW'(1'b1)));
   assign last_row_s = (HW'(y_q) == (height - HW'(1'b1)));

   // Next-state: window shift, raster counters and output qualifiers.
   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      win_d   = win_q;
      valid_d = 1'b0;
      col_d   = col_q;
      row_d   = row_q;
      eof_d   = 1'b0;
      // Oldest row on top: r0 from lb1 (y-2), r1 from lb0 (y-1), r2 is the live pixel.
      new_col_s[0] = lb1_rd_s;
      new_col_s[1] = lb0_rd_s;
      new_col_s[2] = data;
      if (en) begin
         for (int r = 0; r < 3; r++) begin
            win_d[(3*r+0)*DATA_W +: DATA_W] = win_q[(3*r+1)*DATA_W +: DATA_W];
            win_d[(3*r+1)*DATA_W +: DATA_W] = win_q[(3*r+2)*DATA_W +: DATA_W];
            win_d[(3*r+2)*DATA_W +: DATA_W] = new_col_s[r];
         end
         valid_d = (x_q >= CW'(2'd2)) && (y_q >= RW'(2'd2));
         col_d   = x_q - CW'(1'b1);
         row_d   = y_q - RW'(1'b1);
         if (last_col_s) begin
            x_d = '0;
            if (last_row_s) begin
               y_d   = '0;
               eof_d = 1'b1;
            end else begin
               y_d = y_q + RW'(1'b1);
            end
         end else begin
            x_d = x_q + CW'(1'b1);
         end
      end else begin
         valid_d = 1'b0;
         eof_d   = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q     <= '0;
         y_q     <= '0;
         win_q   <= '0;
         valid_q <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
         eof_q   <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         win_q   <= win_d;
         valid_q <= valid_d;
         col_q   <= col_d;
         row_q   <= row_d;
         eof_q   <= eof_d;
      end
   end

   // Line buffers are never reset; the y>=2 gate keeps stale rows invisible.
   always_ff @(posedge clk) begin
      if (en) begin
         lb1_q[x_q] <= lb0_rd_s;
         lb0_q[x_q] <= data;
      end
   end

   assign out       = win_q;
   assign out_valid = valid_q;
   assign col       = col_q;
   assign row       = row_q;
   assign eof       = eof_q;

endmodule

// File: tb/tb_window_3x3.sv
// Directed bench for window_3x3: tap ordering, enable gaps, back-to-back frames,
// full-width row wrap and mid-frame reset.
module tb_window_3x3;

   localparam int DW = 8;
   localparam int MW = 1024;
   localparam int MH = 1024;
   localparam int WW = $clog2(MW + 1);
   localparam int HW = $clog2(MH + 1);
   localparam int CW = $clog2(MW);
   localparam int RW = $clog2(MH);

   logic            clk = 1'b0;
   logic            reset;
   logic            en;
   logic [DW-1:0]   data;
   logic [WW-1:0]   width;
   logic [HW-1:0]   height;
   logic [9*DW-1:0] out;
   logic            out_valid;
   logic [CW-1:0]   col;
   logic [RW-1:0]   row;
   logic            eof;

   int errors = 0;
   int checks = 0;
   int pix_cnt = 0;
   int last_eof_pix = 0;
   int eof_gap = 0;

   window_3x3 #(.DATA_W(DW), .MAX_WIDTH(MW), .MAX_HEIGHT(MH)) dut (
      .clk(clk), .reset(reset), .en(en), .data(data), .width(width), .height(height),
      .out(out), .out_valid(out_valid), .col(col), .row(row), .eof(eof)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pix(int base, int w, int xx, int yy);
      return 8'((base + yy * w + xx) & 255);
   endfunction

   function automatic logic [71:0] win_at(int base, int w, int x, int y);
      logic [71:0] v;
      v = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            v[(3*r+c)*8 +: 8] = pix(base, w, x - 2 + c, y - 2 + r);
      return v;
   endfunction

   task automatic send(input logic [7:0] v);
      en   = 1'b1;
      data = v;
      @(posedge clk);
      #1;
      en = 1'b0;
      pix_cnt++;
   endtask

   task automatic run_frame(input int w, input int h, input int base, input bit gaps,
                            output int nvalid, output int neof, output int last_vcol);
      logic [71:0] held;
      int n;
      bit exp_v;
      nvalid = 0;
      neof = 0;
      last_vcol = -1;
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
               held = out;
               n = $urandom_range(1, 3);
               repeat (n) begin
                  @(posedge clk);
                  #1;
                  check("gap_valid", out_valid, 1'b0);
                  check("gap_taps", out, held);
                  check("gap_eof", eof, 1'b0);
               end
            end
            send(pix(base, w, x, y));
            exp_v = (x >= 2) && (y >= 2);
            check("valid", out_valid, exp_v);
            if (out_valid) begin
               nvalid++;
               last_vcol = int'(col);
            end
            if (exp_v) begin
               check("taps", out, win_at(base, w, x, y));
               check("col", col, x - 1);
               check("row", row, y - 1);
            end
            check("eof", eof, (x == w - 1) && (y == h - 1));
            if (eof) begin
               neof++;
               eof_gap = pix_cnt - last_eof_pix;
               last_eof_pix = pix_cnt;
            end
         end
      end
   endtask

   initial begin
      int nv, ne, lc;
      reset  = 1'b0;
      en     = 1'b0;
      data   = '0;
      width  = WW'(4);
      height = HW'(4);
      repeat (2) @(posedge clk);
      #1;
      check("rst_out", out, 72'h0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_col", col, 0);
      check("rst_row", row, 0);
      check("rst_eof", eof, 1'b0);
      reset = 1'b1;

      // 4x4 frame with pixel value 4y+x; hand-computed first and last windows
      for (int p = 0; p < 16; p++) begin
         send(8'(p));
         check("t1_valid", out_valid, (p == 10) || (p == 11) || (p == 14) || (p == 15));
         check("t1_eof", eof, p == 15);
         if (p == 10) begin
            check("t1_first_taps", out, 72'h0a_09_08_06_05_04_02_01_00);
            check("t1_first_col", col, 1);
            check("t1_first_row", row, 1);
         end
         if (p == 11) check("t1_second_taps", out, 72'h0b_0a_09_07_06_05_03_02_01);
         if (p == 15) begin
            check("t1_last_taps", out, 72'h0f_0e_0d_0b_0a_09_07_06_05);
            check("t1_last_col", col, 2);
            check("t1_last_row", row, 2);
         end
      end
      last_eof_pix = pix_cnt;

      // Same stream with random enable gaps
      run_frame(4, 4, 0, 1'b1, nv, ne, lc);
      check("t2_nvalid", nv, 4);
      check("t2_neof", ne, 1);

      // Back-to-back 5x4 frames, second offset by 100
      width  = WW'(5);
      height = HW'(4);
      run_frame(5, 4, 0, 1'b0, nv, ne, lc);
      check("t3a_nvalid", nv, 6);
      check("t3a_neof", ne, 1);
      run_frame(5, 4, 100, 1'b0, nv, ne, lc);
      check("t3b_nvalid", nv, 6);
      check("t3b_neof", ne, 1);
      check("t3_eof_gap", eof_gap, 20);

      // Full-width row wrap
      width  = WW'(MW);
      height = HW'(3);
      run_frame(MW, 3, 0, 1'b0, nv, ne, lc);
      check("t4_nvalid", nv, MW - 2);
      check("t4_neof", ne, 1);
      check("t4_last_col", lc, MW - 2);

      // Reset mid-frame, then a fresh frame
      width  = WW'(4);
      height = HW'(4);
      for (int p = 0; p < 7; p++) send(8'(p + 200));
      #2;
      reset = 1'b0;
      #1;
      check("t5_rst_out", out, 72'h0);
      check("t5_rst_valid", out_valid, 1'b0);
      check("t5_rst_col", col, 0);
      check("t5_rst_row", row, 0);
      check("t5_rst_eof", eof, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("t5_hold_out", out, 72'h0);
      check("t5_hold_valid", out_valid, 1'b0);
      reset = 1'b1;
      run_frame(4, 4, 50, 1'b0, nv, ne, lc);
      check("t5_nvalid", nv, 4);
      check("t5_neof", ne, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
